// File: rtl/serial_subtract_ctrl.sv
// Bit-serial subtract controller: drives a single full-subtractor cell over
// WIDTH-bit operands, LSB first, one bit per clock. Operands and borrow-in are
// captured when start is accepted in IDLE; the result and final borrow are
// registered on the last bit and announced with a one-cycle done pulse.
//
// Handshake: start is a request that is accepted only on a rising edge where
// the controller is IDLE. In SHIFT or DONE it is ignored, with no queuing.
// busy is high for exactly WIDTH cycles after acceptance. done is high for the
// single following cycle, and diff/bout change only on that transition.
module serial_subtract_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Present and next FSM state. state is the observation point for the FSM.
   state_t state;
   state_t state_nxt;

   logic [WIDTH-1:0] sa;       // minuend shift register
   logic [WIDTH-1:0] sb;       // subtrahend shift register
   logic [WIDTH-1:0] sd;       // difference, filled from the MSB end
   logic [WIDTH-1:0] sd_nxt;
   logic             br;       // running borrow between bit positions
   logic [CW-1:0]    cnt;      // bit index currently being processed
   logic             cell_d;
   logic             cell_b;
   logic             last_bit;

   // The shared full-subtractor cell, applied to the current LSBs.
   assign cell_d   = sa[0] ^ sb[0] ^ br;
   assign cell_b   = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
   assign last_bit = (cnt == CW'(WIDTH - 1));

   // A one-bit result register has nothing to shift; it takes the cell output.
   generate
      if (WIDTH == 1) begin : g_sd_one
         assign sd_nxt = cell_d;
      end else begin : g_sd_wide
         assign sd_nxt = {cell_d, sd[WIDTH-1:1]};
      end
   endgenerate

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and status outputs.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            if (last_bit) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Datapath: operand capture, per-bit shifting and result commit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sa   <= '0;
         sb   <= '0;
         sd   <= '0;
         br   <= 1'b0;
         cnt  <= '0;
         diff <= '0;
         bout <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  sa  <= a;
                  sb  <= b;
                  sd  <= '0;
                  br  <= borrow_in;
                  cnt <= '0;
               end
            end
            SHIFT: begin
               sa  <= sa >> 1;
               sb  <= sb >> 1;
               sd  <= sd_nxt;
               br  <= cell_b;
               cnt <= cnt + CW'(1);
               // Commit only the complete word so diff/bout never show partials.
               if (last_bit) begin
                  diff <= sd_nxt;
                  bout <= cell_b;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtract_ctrl.sv
// Bench for serial_subtract_ctrl. Three instances (WIDTH 8, 13 and 1) share a
// clock and reset. A transaction-level model predicts busy/done/diff/bout for
// each instance every cycle, and directed sequences pin literal results.
module tb_serial_subtract_ctrl;

   logic clk;
   logic rst_n;

   logic [15:0] in_a     [3];
   logic [15:0] in_b     [3];
   logic        in_bin   [3];
   logic        in_start [3];

   logic        busy0, busy1, busy2;
   logic        done0, done1, done2;
   logic [7:0]  diff0;
   logic [12:0] diff1;
   logic [0:0]  diff2;
   logic        bout0, bout1, bout2;

   logic [15:0] o_diff [3];
   logic        o_busy [3];
   logic        o_done [3];
   logic        o_bout [3];

   int n_chk;
   int n_fail;

   serial_subtract_ctrl #(.WIDTH(8)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(in_start[0]),
      .a(in_a[0][7:0]), .b(in_b[0][7:0]), .borrow_in(in_bin[0]),
      .busy(busy0), .done(done0), .diff(diff0), .bout(bout0)
   );

   serial_subtract_ctrl #(.WIDTH(13)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(in_start[1]),
      .a(in_a[1][12:0]), .b(in_b[1][12:0]), .borrow_in(in_bin[1]),
      .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
   );

   serial_subtract_ctrl #(.WIDTH(1)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(in_start[2]),
      .a(in_a[2][0:0]), .b(in_b[2][0:0]), .borrow_in(in_bin[2]),
      .busy(busy2), .done(done2), .diff(diff2), .bout(bout2)
   );

   assign o_diff[0] = {8'd0, diff0};
   assign o_diff[1] = {3'd0, diff1};
   assign o_diff[2] = {15'd0, diff2};
   assign o_busy[0] = busy0;
   assign o_busy[1] = busy1;
   assign o_busy[2] = busy2;
   assign o_done[0] = done0;
   assign o_done[1] = done1;
   assign o_done[2] = done2;
   assign o_bout[0] = bout0;
   assign o_bout[1] = bout1;
   assign o_bout[2] = bout2;

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   function automatic int wid(input int i);
      return (i == 0) ? 8 : ((i == 1) ? 13 : 1);
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s dut%0d: got %0h, expected %0h (t=%0t)", name, idx, act, expv, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Each accepted request occupies the unit for WIDTH shift cycles plus one
   // done cycle; the result is a-b-borrow_in in ordinary integer arithmetic.
   longint      edge_n;
   longint      busy_lo  [3];
   longint      busy_hi  [3];
   longint      done_e   [3];
   longint      free_e   [3];
   logic [15:0] pend_d   [3];
   logic        pend_b   [3];
   logic [15:0] m_diff   [3];
   logic        m_bout   [3];
   logic        m_busy   [3];
   logic        m_done   [3];
   longint      r_tmp;
   longint      mask;

   initial begin
      edge_n = 0;
      for (int i = 0; i < 3; i++) begin
         busy_lo[i] = 1; busy_hi[i] = 0; done_e[i] = -1; free_e[i] = 0;
         pend_d[i] = '0; pend_b[i] = 1'b0;
         m_diff[i] = '0; m_bout[i] = 1'b0; m_busy[i] = 1'b0; m_done[i] = 1'b0;
      end
   end

   always @(posedge clk) begin
      edge_n = edge_n + 1;
      for (int i = 0; i < 3; i++) begin
         mask = (64'sd1 <<< wid(i)) - 1;
         if (!rst_n) begin
            m_diff[i]  = '0;
            m_bout[i]  = 1'b0;
            busy_lo[i] = 1;
            busy_hi[i] = 0;
            done_e[i]  = -1;
            free_e[i]  = edge_n + 1;
         end else begin
            if (in_start[i] && edge_n >= free_e[i]) begin
               r_tmp = (longint'(in_a[i]) & mask) - (longint'(in_b[i]) & mask)
                       - longint'(in_bin[i]);
               pend_d[i]  = 16'(r_tmp & mask);
               pend_b[i]  = (r_tmp < 0);
               busy_lo[i] = edge_n;
               busy_hi[i] = edge_n + wid(i) - 1;
               done_e[i]  = edge_n + wid(i);
               free_e[i]  = edge_n + wid(i) + 2;
            end
            if (edge_n == done_e[i]) begin
               m_diff[i] = pend_d[i];
               m_bout[i] = pend_b[i];
            end
         end
         m_busy[i] = (edge_n >= busy_lo[i]) && (edge_n <= busy_hi[i]);
         m_done[i] = (edge_n == done_e[i]);
      end
   end

   // ---------------- per-cycle compare ----------------
   logic prev_done [3];
   initial for (int i = 0; i < 3; i++) prev_done[i] = 1'b0;

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         chk("busy", i, 32'(o_busy[i]), 32'(m_busy[i]));
         chk("done", i, 32'(o_done[i]), 32'(m_done[i]));
         chk("diff", i, 32'(o_diff[i]), 32'(m_diff[i]));
         chk("bout", i, 32'(o_bout[i]), 32'(m_bout[i]));
         chk("busy_done_excl", i, 32'(o_busy[i] && o_done[i]), 32'd0);
         chk("done_width", i, 32'(o_done[i] && prev_done[i]), 32'd0);
         prev_done[i] = o_done[i];
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_op(input int idx, input logic [15:0] av, input logic [15:0] bv,
                        input logic binv, input logic [15:0] ed, input logic eb);
      int n;
      n = 0;
      while ((o_busy[idx] || o_done[idx]) && n < 40) begin
         @(negedge clk);
         n++;
      end
      in_a[idx] = av; in_b[idx] = bv; in_bin[idx] = binv; in_start[idx] = 1'b1;
      @(negedge clk);
      in_start[idx] = 1'b0;
      in_a[idx]     = 16'($urandom);
      in_b[idx]     = 16'($urandom);
      in_bin[idx]   = 1'($urandom_range(0, 1));
      n = 1;
      while (!o_done[idx] && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("latency", idx, 32'(n), 32'(wid(idx) + 1));
      chk("lit_diff", idx, 32'(o_diff[idx]), 32'(ed));
      chk("lit_bout", idx, 32'(o_bout[idx]), 32'(eb));
      @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   logic [1:0] tt [8];
   int busy_run;
   int ndone;
   int last_done;

   initial begin
      tt = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
      n_chk  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_a[i] = '0; in_b[i] = '0; in_bin[i] = 1'b0; in_start[i] = 1'b0;
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("rst_busy", i, 32'(o_busy[i]), 32'd0);
         chk("rst_done", i, 32'(o_done[i]), 32'd0);
         chk("rst_diff", i, 32'(o_diff[i]), 32'd0);
         chk("rst_bout", i, 32'(o_bout[i]), 32'd0);
      end

      // T1 / T2
      do_op(0, 16'h05, 16'h03, 1'b0, 16'h02, 1'b0);
      do_op(0, 16'h03, 16'h05, 1'b0, 16'hFE, 1'b1);
      do_op(0, 16'h00, 16'h00, 1'b1, 16'hFF, 1'b1);
      do_op(1, 16'h0000, 16'h0001, 1'b0, 16'h1FFF, 1'b1);
      do_op(1, 16'h1234, 16'h0234, 1'b1, 16'h0FFF, 1'b0);

      // T3: start held high; operands scrambled whenever they must be ignored
      in_start[0] = 1'b1;
      busy_run = 0; ndone = 0; last_done = -1;
      for (int c = 0; c < 40; c++) begin
         if (o_busy[0] || o_done[0]) begin
            in_a[0] = 16'($urandom); in_b[0] = 16'($urandom);
            in_bin[0] = 1'($urandom_range(0, 1));
         end else begin
            in_a[0] = 16'h10; in_b[0] = 16'h01; in_bin[0] = 1'b0;
         end
         @(negedge clk);
         if (o_busy[0]) busy_run++;
         if (o_done[0]) begin
            chk("t3_diff", 0, 32'(o_diff[0]), 32'h0F);
            chk("t3_busy_len", 0, 32'(busy_run), 32'd8);
            if (last_done >= 0) chk("t3_interval", 0, 32'(c - last_done), 32'd10);
            busy_run  = 0;
            last_done = c;
            ndone++;
         end
      end
      in_start[0] = 1'b0;
      chk("t3_done_count", 0, 32'(ndone), 32'd4);

      // T4: reset during the fourth shift cycle
      while (o_busy[0] || o_done[0]) @(negedge clk);
      in_a[0] = 16'h33; in_b[0] = 16'h11; in_bin[0] = 1'b0; in_start[0] = 1'b1;
      @(negedge clk);
      in_start[0] = 1'b0;
      repeat (3) @(negedge clk);
      chk("t4_busy_before", 0, 32'(o_busy[0]), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("t4_busy", 0, 32'(o_busy[0]), 32'd0);
      chk("t4_done", 0, 32'(o_done[0]), 32'd0);
      chk("t4_diff", 0, 32'(o_diff[0]), 32'd0);
      chk("t4_bout", 0, 32'(o_bout[0]), 32'd0);
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         chk("t4_no_done", 0, 32'(o_done[0]), 32'd0);
      end
      do_op(0, 16'h33, 16'h11, 1'b0, 16'h22, 1'b0);

      // T5: WIDTH=1 truth table, index = {a,b,borrow_in}
      for (int k = 0; k < 8; k++) begin
         do_op(2, 16'((k >> 2) & 1), 16'((k >> 1) & 1), 1'(k & 1),
               16'(tt[k][1]), tt[k][0]);
      end

      // T6: random traffic on all instances with rare resets
      for (int c = 0; c < 8000; c++) begin
         rst_n = ($urandom_range(0, 499) != 0);
         for (int i = 0; i < 3; i++) begin
            in_start[i] = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
               0:       in_a[i] = 16'h0000;
               1:       in_a[i] = 16'hFFFF;
               default: in_a[i] = 16'($urandom);
            endcase
            case ($urandom_range(0, 3))
               0:       in_b[i] = 16'h0000;
               1:       in_b[i] = 16'hFFFF;
               default: in_b[i] = 16'($urandom);
            endcase
            in_bin[i] = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) in_start[i] = 1'b0;
      repeat (20) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // ---------------- watchdog ----------------
   initial begin
      #2000000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $fatal(1, "time limit");
   end

endmodule
